// File: rtl/mlaccel_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mlaccel_top
// Brief    : QPI-style nibble-serial slave in front of a 256-byte buffer.
//            Host commands 0x21 (write) and 0x22 (read with N turnaround
//            bytes); anything else latches an error until the next select.
// Revision : 1.0 - initial release
// ============================================================================
module mlaccel_top (
  input  logic clock,
  input  logic reset,
  input  logic qpi_csb,
  input  logic qpi_clk,
  inout  wire  qpi_io0,
  inout  wire  qpi_io1,
  inout  wire  qpi_io2,
  inout  wire  qpi_io3,
  output logic qpi_rdy,
  output logic qpi_err
);

  localparam logic [7:0] CMD_WRITE = 8'h21;
  localparam logic [7:0] CMD_READ  = 8'h22;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ARG1  = 3'd2,
    ADDR  = 3'd3,
    WDATA = 3'd4,
    DUMMY = 3'd5,
    RDATA = 3'd6,
    ERR   = 3'd7
  } state_t;

  state_t state;
  state_t state_next;

  // Synchronised host pins and their previous samples (idle: csb=1, clk=1)
  logic       csb_s;
  logic       csb_p;
  logic       clk_s;
  logic       clk_p;
  logic [3:0] io_s;

  // Byte assembly
  logic [3:0] hi_cap;
  logic       have_hi;

  // Transaction context
  logic       is_read;
  logic [3:0] dummy_cnt;
  logic [7:0] addr;

  // Read-out nibble registers
  logic [3:0] hi_out;
  logic [3:0] lo_out;

  // Buffer
  logic [7:0] mem [256];

  // Derived events
  logic       clk_rise;
  logic       clk_fall;
  logic       csb_rise;
  logic       csb_fall;
  logic       nib_fall;
  logic       byte_done;
  logic [7:0] byte_val;
  logic [7:0] addr_inc;
  logic       mem_we;
  logic       cmd_ok;
  logic       drive_en;
  logic [3:0] io_out;
  logic [3:0] io_in;

  assign io_in = {qpi_io3, qpi_io2, qpi_io1, qpi_io0};

  // Sample host pins once per clock and keep the previous sample for edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      csb_s <= 1'b1;
      csb_p <= 1'b1;
      clk_s <= 1'b1;
      clk_p <= 1'b1;
      io_s  <= 4'h0;
    end else begin
      csb_s <= qpi_csb;
      csb_p <= csb_s;
      clk_s <= qpi_clk;
      clk_p <= clk_s;
      io_s  <= io_in;
    end
  end

  assign clk_rise  = clk_s & ~clk_p;
  assign clk_fall  = ~clk_s & clk_p;
  assign csb_rise  = csb_s & ~csb_p;
  assign csb_fall  = ~csb_s & csb_p;
  // A falling qpi_clk edge carries the high nibble, the following rise the low one
  assign nib_fall  = ~csb_s & clk_fall;
  assign byte_done = ~csb_s & clk_rise & have_hi;
  assign byte_val  = {hi_cap, io_s};
  assign addr_inc  = addr + 8'd1;
  assign cmd_ok    = (byte_val == CMD_WRITE) || (byte_val == CMD_READ);
  assign mem_we    = byte_done && (state == WDATA);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: every completed byte advances until a data phase is reached
  always_comb begin
    state_next = state;
    if (csb_rise) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (csb_fall) state_next = CMD;
        end
        CMD: begin
          if (byte_done) state_next = cmd_ok ? ARG1 : ERR;
        end
        ARG1: begin
          if (byte_done) state_next = ADDR;
        end
        ADDR: begin
          if (byte_done) begin
            if (!is_read)             state_next = WDATA;
            else if (dummy_cnt == 4'd0) state_next = RDATA;
            else                       state_next = DUMMY;
          end
        end
        DUMMY: begin
          if (byte_done && (dummy_cnt == 4'd1)) state_next = RDATA;
        end
        default: begin
          state_next = state;
        end
      endcase
    end
  end

  // Byte assembly, transaction context, read nibble pipeline and status flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_cap    <= 4'h0;
      have_hi   <= 1'b0;
      is_read   <= 1'b0;
      dummy_cnt <= 4'h0;
      addr      <= 8'h00;
      hi_out    <= 4'h0;
      lo_out    <= 4'h0;
      qpi_err   <= 1'b0;
      qpi_rdy   <= 1'b0;
    end else begin
      qpi_rdy <= 1'b1;

      if (csb_fall) qpi_err <= 1'b0;

      // A csb rise throws away a half-received byte
      if (csb_rise) begin
        have_hi <= 1'b0;
      end else if (nib_fall) begin
        hi_cap  <= io_s;
        have_hi <= 1'b1;
      end else if (byte_done) begin
        have_hi <= 1'b0;
      end

      if (byte_done) begin
        case (state)
          CMD: begin
            is_read <= (byte_val == CMD_READ);
            if (!cmd_ok) qpi_err <= 1'b1;
          end
          ARG1: begin
            dummy_cnt <= byte_val[3:0];
          end
          ADDR: begin
            addr <= byte_val;
            // No turnaround: the first high nibble must be ready for the next fall
            if (is_read && (dummy_cnt == 4'd0)) hi_out <= mem[byte_val][7:4];
          end
          WDATA: begin
            addr <= addr_inc;
          end
          DUMMY: begin
            dummy_cnt <= dummy_cnt - 4'd1;
            if (dummy_cnt == 4'd1) hi_out <= mem[addr][7:4];
          end
          RDATA: begin
            addr   <= addr_inc;
            hi_out <= mem[addr_inc][7:4];
          end
          default: begin
          end
        endcase
      end

      // Low nibble of the byte in flight is fetched while the host holds clk low
      if (nib_fall && (state == RDATA)) lo_out <= mem[addr][3:0];
    end
  end

  // Buffer storage, cleared as a whole by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[addr] <= byte_val;
    end
  end

  // Pads are driven only while reading with the device selected; nibble follows raw qpi_clk
  assign drive_en = (state == RDATA) && !csb_s;
  assign io_out   = qpi_clk ? lo_out : hi_out;

  assign qpi_io0 = drive_en ? io_out[0] : 1'bz;
  assign qpi_io1 = drive_en ? io_out[1] : 1'bz;
  assign qpi_io2 = drive_en ? io_out[2] : 1'bz;
  assign qpi_io3 = drive_en ? io_out[3] : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_mlaccel_top.sv
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mlaccel_top
// Brief    : Scoreboard bench for mlaccel_top; host-side QPI driver plus a
//            byte-array model of the buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mlaccel_top;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic       qpi_csb = 1'b1;
  logic       qpi_clk = 1'b1;
  logic       host_oe = 1'b0;
  logic [3:0] host_io = 4'h0;
  logic       qpi_rdy;
  logic       qpi_err;

  wire io0;
  wire io1;
  wire io2;
  wire io3;

  // Undriven pads read back as ones
  pullup (io0);
  pullup (io1);
  pullup (io2);
  pullup (io3);

  assign io0 = host_oe ? host_io[0] : 1'bz;
  assign io1 = host_oe ? host_io[1] : 1'bz;
  assign io2 = host_oe ? host_io[2] : 1'bz;
  assign io3 = host_oe ? host_io[3] : 1'bz;

  wire [3:0] io_bus = {io3, io2, io1, io0};

  mlaccel_top dut (
    .clock   (clock),
    .reset   (reset),
    .qpi_csb (qpi_csb),
    .qpi_clk (qpi_clk),
    .qpi_io0 (io0),
    .qpi_io1 (io1),
    .qpi_io2 (io2),
    .qpi_io3 (io3),
    .qpi_rdy (qpi_rdy),
    .qpi_err (qpi_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      nm;
    logic [7:0] v;
  } item_t;

  item_t      exp_q[$];
  item_t      obs_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] model [256];

  function automatic void expect_item(input string nm, input logic [7:0] v);
    item_t it;
    it.nm = nm;
    it.v  = v;
    exp_q.push_back(it);
  endfunction

  function automatic void observe(input string nm, input logic [7:0] v);
    item_t it;
    it.nm = nm;
    it.v  = v;
    obs_q.push_back(it);
  endfunction

  // Monitor: pairs each observed DUT output with the oldest expectation
  initial begin
    forever begin
      @(negedge clock);
      while (obs_q.size() > 0) begin
        item_t o;
        item_t e;
        o = obs_q.pop_front();
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s: got %02h, nothing expected", o.nm, o.v);
        end else begin
          e = exp_q.pop_front();
          if ((e.nm != o.nm) || (o.v !== e.v)) begin
            n_fail++;
            $display("FAIL %s: got %02h required %02h (%s)", o.nm, o.v, e.v, e.nm);
          end
        end
      end
    end
  end

  // One byte on the bus: hi nibble captured at the fall, lo nibble at the rise.
  // io is sampled 15 ns after each edge; host releases io before the device can drive.
  task automatic qbyte(input logic [7:0] b, input bit drv, output logic [7:0] rx);
    host_oe = drv;
    host_io = b[7:4];
    #2  qpi_clk = 1'b0;
    #12 host_io = b[3:0];
    #3  rx[7:4] = io_bus;
    #2  qpi_clk = 1'b1;
    #10 host_oe = 1'b0;
    #5  rx[3:0] = io_bus;
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] d;
    qbyte(b, 1'b1, d);
  endtask

  task automatic cs_begin();
    qpi_clk = 1'b1;
    host_oe = 1'b0;
    qpi_csb = 1'b0;
    #30;
  endtask

  task automatic cs_end();
    #5 qpi_csb = 1'b1;
    #40;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] data[$]);
    logic [7:0] p;
    p = a;
    cs_begin();
    send(8'h21);
    send(8'($urandom));
    send(a);
    foreach (data[i]) begin
      send(data[i]);
      model[p] = data[i];
      p++;
    end
    cs_end();
  endtask

  task automatic do_read(input logic [3:0] n, input logic [7:0] a, input int len, input string nm);
    logic [7:0] rx;
    logic [7:0] p;
    p = a;
    cs_begin();
    send(8'h22);
    send({4'($urandom), n});
    send(a);
    repeat (n) qbyte(8'h00, 1'b0, rx);
    for (int i = 0; i < len; i++) begin
      expect_item(nm, model[p]);
      qbyte(8'h00, 1'b0, rx);
      observe(nm, rx);
      p++;
    end
    cs_end();
  endtask

  // Watchdog
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d[$];
    logic [7:0] rx;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;

    #2.5;
    #20;
    expect_item("reset_rdy", 8'h00); observe("reset_rdy", {7'd0, qpi_rdy});
    expect_item("reset_err", 8'h00); observe("reset_err", {7'd0, qpi_err});
    expect_item("reset_io",  8'h0F); observe("reset_io",  {4'h0, io_bus});
    reset = 1'b0;
    #40;
    expect_item("run_rdy", 8'h01); observe("run_rdy", {7'd0, qpi_rdy});

    // Write twelve bytes at 0x10, read back with three turnaround bytes
    d.delete();
    for (int i = 1; i <= 12; i++) d.push_back(8'(i));
    do_write(8'h10, d);
    do_read(4'd3, 8'h10, 17, "wr_rd");

    // Address wrap 0xFF -> 0x00
    d.delete();
    d.push_back(8'hAA); d.push_back(8'hBB); d.push_back(8'hCC);
    do_write(8'hFE, d);
    do_read(4'd0, 8'hFE, 3, "wrap");

    // Unknown command: error flag, pads idle, trailing bytes ignored
    cs_begin();
    send(8'h55);
    #10;
    expect_item("bad_err", 8'h01); observe("bad_err", {7'd0, qpi_err});
    for (int i = 0; i < 2; i++) begin
      expect_item("bad_hiz", 8'hFF);
      qbyte(8'h00, 1'b0, rx);
      observe("bad_hiz", rx);
    end
    send(8'h00); send(8'h30); send(8'h77);
    cs_end();
    expect_item("bad_err_hold", 8'h01); observe("bad_err_hold", {7'd0, qpi_err});
    qpi_csb = 1'b0;
    #30;
    expect_item("err_clear", 8'h00); observe("err_clear", {7'd0, qpi_err});
    send(8'h22); send(8'h00); send(8'h30);
    expect_item("bad_nowrite", model[8'h30]);
    qbyte(8'h00, 1'b0, rx);
    observe("bad_nowrite", rx);
    cs_end();

    // Truncated transactions
    cs_begin(); send(8'h21); send(8'h00); cs_end();
    cs_begin(); send(8'h21); send(8'h00); send(8'h40);
    host_oe = 1'b1; host_io = 4'hA;
    #2  qpi_clk = 1'b0;
    #12 qpi_csb = 1'b1;
    #20 qpi_clk = 1'b1;
    host_oe = 1'b0;
    #40;
    do_read(4'd1, 8'h40, 2, "trunc");

    // Randomised traffic against the array model
    for (int t = 0; t < 16; t++) begin
      logic [7:0] a;
      int         len;
      a   = 8'($urandom);
      len = int'($urandom_range(1, 8));
      if ($urandom_range(0, 1) == 1) begin
        d.delete();
        for (int i = 0; i < len; i++) d.push_back(8'($urandom));
        do_write(a, d);
      end else begin
        do_read(4'($urandom_range(0, 3)), a, len, "rand_rd");
      end
    end

    // Reset during a read data phase
    d.delete();
    d.push_back(8'h01); d.push_back(8'h02);
    do_write(8'h10, d);
    cs_begin();
    send(8'h22); send(8'h00); send(8'h10);
    expect_item("rst_pre", model[8'h10]);
    qbyte(8'h00, 1'b0, rx);
    observe("rst_pre", rx);
    host_oe = 1'b0;
    #2  qpi_clk = 1'b0;
    #15;
    expect_item("rst_hi", {4'h0, model[8'h11][7:4]}); observe("rst_hi", {4'h0, io_bus});
    reset = 1'b1;
    #1;
    expect_item("rst_io",  8'h0F); observe("rst_io",  {4'h0, io_bus});
    expect_item("rst_rdy", 8'h00); observe("rst_rdy", {7'd0, qpi_rdy});
    #5  qpi_clk = 1'b1;
    qpi_csb = 1'b1;
    #30 reset = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    #40;
    expect_item("post_rst_rdy", 8'h01); observe("post_rst_rdy", {7'd0, qpi_rdy});
    do_read(4'd0, 8'h10, 2, "post_rst");

    // Let the monitor drain, then account for anything never observed
    for (int i = 0; i < 100; i++) begin
      if (obs_q.size() == 0) break;
      @(posedge clock);
    end
    @(negedge clock);
    @(negedge clock);
    while (exp_q.size() > 0) begin
      item_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got nothing required %02h", e.nm, e.v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mlaccel_top.md
MLACCEL_TOP -- requirements
Module: mlaccel_top

Interface
REQ-001 The block SHALL have the following ports (one clock; reset is asynchronous, active-high):
- clock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- qpi_csb  in  1  host chip select, active low
- qpi_clk  in  1  host serial clock; idles high
- qpi_io0..qpi_io3  inout  1 each  nibble bus; io3 = MSB
- qpi_rdy  out  1  device ready
- qpi_err  out  1  protocol error flag

REQ-002 The block SHALL have no parameters: 256-byte buffer, 8-bit address.

Function
REQ-003 The block SHALL register qpi_csb, qpi_clk and qpi_io[3:0] once per clock, and SHALL detect qpi_clk edges by comparing the current sample with the previous sample.
REQ-004 The block SHALL support qpi_clk half-periods of 1.5 clock periods or more.
REQ-005 While csb is low, a detected falling edge of qpi_clk SHALL capture io as the high nibble, and the next detected rising edge SHALL capture the low nibble and complete one byte.
REQ-006 A detected csb rise SHALL end the transaction, discard any partial byte, and return the state machine to IDLE.
REQ-007 The state machine SHALL have the states IDLE, CMD, ARG1, ADDR, WDATA, DUMMY, RDATA and ERR.
- A detected csb fall SHALL move IDLE to CMD.
- Each completed byte SHALL advance the state.
REQ-008 Command 0x21 (write) SHALL be handled as follows.
- byte1 is reserved and ignored; byte2 is the start address.
- Each following byte SHALL be written to the buffer at the current address.
- The address SHALL then increment modulo 256, wrapping from 0xFF to 0x00.
REQ-009 Command 0x22 (read) SHALL be handled as follows.
- byte1[3:0] = N dummy (turnaround) bytes; byte2 = start address.
- After N dummy bytes, the block SHALL return buffer bytes from the start address, incrementing modulo 256, until csb rises.
REQ-010 During the read data phase, io SHALL be driven combinationally from the raw qpi_clk.
- qpi_clk low: drive the hi-nibble register.
- qpi_clk high: drive the lo-nibble register.
REQ-011 The nibble registers SHALL update as follows.
- hi-nibble: loaded with byte[7:4] of the next output byte on each detected rising edge.
- lo-nibble: loaded with byte[3:0] on each detected falling edge.
- The first data byte's high nibble SHALL be loaded at the rising edge that completes the last dummy byte, or the address byte when N=0.
REQ-012 The io pins SHALL be high-Z at all times except in RDATA with csb low, and SHALL release within one clock of a detected csb rise.
REQ-013 A command byte other than 0x21 or 0x22 SHALL move the block to ERR and set qpi_err=1.
- In ERR, the block SHALL ignore further bytes and drive nothing.
- qpi_err SHALL clear on the next detected csb fall.
REQ-014 qpi_rdy SHALL be 1 whenever the block is out of reset, and SHALL be 0 while reset is asserted.
REQ-015 A transaction that ends before its address byte completes SHALL have no effect on the buffer.

Reset
REQ-016 Asserting reset SHALL apply immediately, regardless of the clock, and SHALL set:
- state = IDLE;
- all 256 buffer bytes = 0x00;
- qpi_err = 0, qpi_rdy = 0;
- io = high-Z;
- synchronizer samples = idle values (csb=1, clk=1).
REQ-017 Reset asserted mid-transaction SHALL abort that transaction; the host SHALL restart with a csb fall.

Verification
REQ-018 Write then read:
- write: 21 01 10 01 02 ... 0C (12 data bytes);
- read: 22 03 10, then 20 received bytes;
- response: 3 dummy bytes, then 01..0C, then five 0x00 bytes.
REQ-019 Wrap-around: write 21 00 FE AA BB CC -> buffer[FE]=AA, buffer[FF]=BB, buffer[00]=CC; read 22 00 FE, then 3 bytes -> AA BB CC.
REQ-020 Bad command:
- send 0x55 -> qpi_err=1, io stays high-Z, buffer unchanged;
- the next valid transaction's csb fall -> qpi_err=0.
REQ-021 Truncated transaction:
- 21 00 (csb raised) -> buffer unchanged;
- a partial nibble followed by a csb rise -> no write;
- a read of that address -> 0x00.
REQ-022 Reset:
- assert reset during a read data phase -> io high-Z and qpi_rdy=0 within the same cycle;
- after release, a read of 0x10 -> 0x00.
REQ-023 Timing: the bench SHALL run a 10 ns clock with a 17 ns qpi_clk half-period, and SHALL sample io 15 ns after each qpi_clk edge.
